// File: rtl/fir_transposed_prog.sv
// Programmable transposed-form FIR with valid-qualified streaming, double-buffered
// coefficients (atomic swap), round-half-up scaling, saturation and delay-line flush.
module fir_transposed_prog #(
    parameter int N          = 9,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int FRAC_SHIFT = 15,
    localparam int AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              coef_wr_en,
    input  logic [AW-1:0]     coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    input  logic              coef_swap,
    input  logic              flush,
    output logic              sat_flag,
    input  logic              sat_clr
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(N) + 1;
    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic signed [ACC_W:0] RND =
        (FRAC_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [COEF_W-1:0] shadow_q [N];
    logic signed [COEF_W-1:0] act_q    [N];
    logic signed [PROD_W-1:0] m        [N];
    logic signed [ACC_W-1:0]  r_q      [N-1];
    logic signed [ACC_W-1:0]  r_d      [N-1];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    acc_rnd;
    logic signed [ACC_W:0]    s;
    logic                     accept;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [DATA_W-1:0]        out_data_q;
    logic [DATA_W-1:0]        out_data_d;
    logic                     out_valid_q;
    logic                     sat_q;
    logic                     sat_d;

    always_comb begin
        accept = in_valid && !flush;
        for (int unsigned k = 0; k < N; k++) begin
            m[k] = $signed(in_data) * act_q[k];
        end
        acc = ACC_W'(m[0]) + r_q[0];
        for (int unsigned i = 0; i < N - 2; i++) begin
            r_d[i] = ACC_W'(m[i+1]) + r_q[i+1];
        end
        r_d[N-2] = ACC_W'(m[N-1]);

        // One extra bit of headroom so the rounding offset cannot wrap.
        acc_rnd = (ACC_W + 1)'(acc) + RND;
        s       = acc_rnd >>> FRAC_SHIFT;
        sat_hi  = s > SAT_MAX;
        sat_lo  = s < SAT_MIN;

        if (sat_hi) begin
            out_data_d = OUT_MAX;
        end else if (sat_lo) begin
            out_data_d = OUT_MIN;
        end else begin
            out_data_d = s[DATA_W-1:0];
        end

        // A new saturation event takes priority over a clear in the same cycle.
        if (accept && (sat_hi || sat_lo)) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // Swap copies the registered shadow, so a same-cycle write lands in shadow only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
                act_q[k]    <= '0;
            end
        end else begin
            if (coef_wr_en && (32'(coef_wr_addr) < N)) begin
                shadow_q[coef_wr_addr] <= coef_wr_data;
            end
            if (coef_swap) begin
                for (int unsigned k = 0; k < N; k++) begin
                    act_q[k] <= shadow_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N - 1; i++) begin
                r_q[i] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            sat_q       <= sat_d;
            out_valid_q <= accept;
            if (flush) begin
                for (int unsigned i = 0; i < N - 1; i++) begin
                    r_q[i] <= '0;
                end
            end else if (in_valid) begin
                r_q        <= r_d;
                out_data_q <= out_data_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_transposed_prog.sv
// Scoreboard bench for fir_transposed_prog: stimulus pushes expected outputs,
// an independent monitor pops and compares on every out_valid pulse.
module tb_fir_transposed_prog;

    localparam int N  = 9;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FS = 15;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          coef_wr_en = 1'b0;
    logic [AW-1:0] coef_wr_addr = '0;
    logic [CW-1:0] coef_wr_data = '0;
    logic          coef_swap = 1'b0;
    logic          flush = 1'b0;
    logic          sat_clr = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          sat_flag;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int last_exp = 0;

    int              hx[$];
    logic [N*CW-1:0] hc[$];
    logic [N*CW-1:0] act_m = '0;
    logic [N*CW-1:0] sh_m = '0;

    fir_transposed_prog #(
        .N(N),
        .DATA_W(DW),
        .COEF_W(CW),
        .FRAC_SHIFT(FS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .coef_wr_en(coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .coef_swap(coef_swap),
        .flush(flush),
        .sat_flag(sat_flag),
        .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    // Direct-form reference: tap k of output n uses sample n-k with the set active when it arrived.
    function automatic int model();
        longint          acc;
        longint          s;
        int              n;
        logic [N*CW-1:0] c;
        logic signed [CW-1:0] h;
        acc = 0;
        n = hx.size();
        for (int k = 0; k < N; k++) begin
            if (k < n) begin
                c = hc[n-1-k];
                h = c[k*CW +: CW];
                acc += longint'(hx[n-1-k]) * longint'(h);
            end
        end
        s = (acc + 64'sd16384) >>> FS;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic cyc(input logic v, input int x, input logic fl, input logic we,
                       input int wa, input int wd, input logic sw, input logic sc,
                       input logic hand, input int hexp);
        logic [N*CW-1:0] pre;
        int e;
        in_valid     = v;
        in_data      = x[DW-1:0];
        flush        = fl;
        coef_wr_en   = we;
        coef_wr_addr = wa[AW-1:0];
        coef_wr_data = wd[CW-1:0];
        coef_swap    = sw;
        sat_clr      = sc;
        pre = sh_m;
        if (fl) begin
            hx.delete();
            hc.delete();
        end else if (v) begin
            hx.push_back(x);
            hc.push_back(act_m);
            if (hx.size() > N) begin
                void'(hx.pop_front());
                void'(hc.pop_front());
            end
            e = model();
            exp_q.push_back(hand ? hexp : e);
        end
        if (we && wa < N) sh_m[wa*CW +: CW] = wd[CW-1:0];
        if (sw) act_m = pre;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        coef_wr_en = 1'b0;
        coef_swap  = 1'b0;
        sat_clr    = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic samp(input int x, input int hexp);
        cyc(1, x, 0, 0, 0, 0, 0, 0, 1, hexp);
    endtask

    task automatic wr(input int a, input int d);
        cyc(0, 0, 0, 1, a, d, 0, 0, 0, 0);
    endtask

    task automatic swp();
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic load_impulse();
        for (int k = 0; k < N; k++) wr(k, 1024 * (k + 1));
        swp();
    endtask

    task automatic impulse(input bit gaps);
        int guard;
        for (int i = 0; i < 13; i++) begin
            guard = 0;
            while (gaps && ($urandom_range(0, 99) >= 40) && guard < 20) begin
                idle();
                guard++;
            end
            samp((i == 0) ? 16384 : 0, (i < N) ? 512 * (i + 1) : 0);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 20) begin
            idle();
            b++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got=%0d expected=none", int'($signed(out_data)));
                end else begin
                    last_exp = exp_q.pop_front();
                    if (int'($signed(out_data)) != last_exp) begin
                        failures++;
                        $display("FAIL out_data: got=%0d expected=%0d", int'($signed(out_data)), last_exp);
                    end
                end
            end else if (int'($signed(out_data)) != last_exp) begin
                failures++;
                $display("FAIL out_hold: got=%0d expected=%0d", int'($signed(out_data)), last_exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'($signed(out_data)), 0);
        chk("reset_sat_flag", int'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        samp(1234, 0);
        load_impulse();
        impulse(0);
        drain();
        chk("impulse_sat_flag", int'(sat_flag), 0);

        for (int k = 0; k < N; k++) wr(k, (k == 0) ? 1 : 0);
        swp();
        samp(16384, 1);
        samp(16383, 0);
        samp(-16384, 0);
        samp(-16385, -1);
        drain();

        for (int k = 0; k < N; k++) wr(k, 32767);
        swp();
        samp(32767, 32766);
        repeat (9) samp(32767, 32767);
        drain();
        chk("sat_flag_set", int'(sat_flag), 1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, -32768, 0, 0, 0, 0, 0, (i == 6), 1,
                (i < 3) ? 32767 : (i == 3) ? 32762 : -32768);
            if (i == 6) chk("sat_clr_while_sat", int'(sat_flag), 1);
        end
        for (int i = 0; i < N; i++) samp(0, (i < 7) ? -32768 : (i == 7) ? -32767 : 0);
        drain();
        chk("sat_flag_before_clr", int'(sat_flag), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("sat_flag_cleared", int'(sat_flag), 0);

        load_impulse();
        impulse(1);
        drain();
        chk("gaps_sat_flag", int'(sat_flag), 0);

        // Set B written under streaming; addr N is ignored; B[8] written in the swap cycle.
        for (int k = 0; k < N - 1; k++) cyc(1, 700 * k - 2000, 0, 1, k, -700 + 300 * k, 0, 0, 0, 0);
        cyc(1, 3000, 0, 1, N, 12345, 0, 0, 0, 0);
        cyc(1, -2500, 0, 1, N - 1, 1700, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1500 - 900 * i, 0, 0, 0, 0, 0, 0, 0, 0);
        swp();
        for (int i = 0; i < 10; i++) cyc(1, 400 * i - 1800, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        load_impulse();
        samp(16384, 512);
        samp(0, 1024);
        samp(0, 1536);
        samp(0, 2048);
        cyc(1, 16384, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_out_data", int'($signed(out_data)), 2048);
        impulse(0);
        drain();

        samp(16384, 512);
        samp(0, 1024);
        samp(0, 1536);
        samp(0, 2048);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_data", int'($signed(out_data)), 0);
        chk("async_rst_sat_flag", int'(sat_flag), 0);
        exp_q.delete();
        hx.delete();
        hc.delete();
        act_m = '0;
        sh_m = '0;
        last_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        samp(16384, 0);
        load_impulse();
        impulse(0);
        drain();
        chk("final_sat_flag", int'(sat_flag), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
